// File: rtl/tagged_flux_buffer_if.sv
// +--------------------------------------------------------------------------+
// | tagged_flux_buffer_if : tagged token in/out bundle with occupancy status |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface tagged_flux_buffer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FLUX       = 2,
  parameter int DEPTH      = 16
);
  localparam int TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 1;
  localparam int CNT_WIDTH = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH+TAG_WIDTH-1:0] in_din;
  logic                            in_write;
  logic [FLUX-1:0]                 in_full;
  logic [DATA_WIDTH+TAG_WIDTH-1:0] out_din;
  logic                            out_write;
  logic [FLUX-1:0]                 out_full;
  logic [FLUX*CNT_WIDTH-1:0]       occupancy;
  logic                            drop_err;

  modport slave (
    input  in_din, in_write, out_full,
    output in_full, out_din, out_write, occupancy, drop_err
  );

  modport master (
    output in_din, in_write, out_full,
    input  in_full, out_din, out_write, occupancy, drop_err
  );
endinterface

`default_nettype wire

// File: rtl/tagged_flux_buffer.sv
// +--------------------------------------------------------------------------+
// | tagged_flux_buffer : tag-steered per-flux FIFOs merged by a round-robin  |
// | arbiter honouring per-flux downstream full flags.   Revision 1.0         |
// +--------------------------------------------------------------------------+
`default_nettype none

module tagged_flux_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int FLUX       = 2,
  parameter int DEPTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  tagged_flux_buffer_if.slave  bus
);
  localparam int TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 1;
  localparam int CNT_WIDTH = $clog2(DEPTH) + 1;
  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam int TAG_SPAN  = 1 << TAG_WIDTH;

  logic [TAG_WIDTH-1:0]             tag;
  logic [DATA_WIDTH-1:0]            payload;
  logic [FLUX-1:0]                  full;
  logic [TAG_SPAN-1:0]              full_ext;
  logic                             push_ok;
  logic [FLUX-1:0]                  eligible;
  logic [FLUX-1:0][DATA_WIDTH-1:0]  heads;
  logic                             grant_valid;
  logic [TAG_WIDTH-1:0]             grant_idx;
  logic [TAG_WIDTH-1:0]             rr_q;
  logic                             drop_q;
  int                               scan;

  assign tag      = bus.in_din[DATA_WIDTH +: TAG_WIDTH];
  assign payload  = bus.in_din[DATA_WIDTH-1:0];
  // Out-of-range tags index the zero-padded upper part of full_ext.
  assign full_ext = TAG_SPAN'(full);
  assign push_ok  = bus.in_write && (int'(tag) < FLUX) && !full_ext[tag];

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan        = 0;
    for (int k = 1; k <= FLUX; k++) begin
      scan = (int'(rr_q) + k) % FLUX;
      if (!grant_valid && eligible[scan]) begin
        grant_valid = 1'b1;
        grant_idx   = TAG_WIDTH'(scan);
      end
    end
  end

  for (genvar f = 0; f < FLUX; f++) begin : g_flux
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr_q;
    logic [PTR_WIDTH-1:0]  rd_ptr_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [CNT_WIDTH-1:0]  cnt_d;
    logic                  push;
    logic                  pop;

    assign push = push_ok && (int'(tag) == f);
    assign pop  = grant_valid && (int'(grant_idx) == f);

    always_comb begin
      cnt_d = cnt_q;
      if (push && !pop) cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= payload;
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        cnt_q <= cnt_d;
      end
    end

    assign heads[f]    = mem_q[rd_ptr_q];
    assign full[f]     = (cnt_q == CNT_WIDTH'(DEPTH));
    assign eligible[f] = (cnt_q != '0) && !bus.out_full[f];
    assign bus.occupancy[f*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_q   <= TAG_WIDTH'(FLUX - 1);
      drop_q <= 1'b0;
    end else begin
      if (grant_valid) rr_q <= grant_idx;
      if (bus.in_write && !push_ok) drop_q <= 1'b1;
    end
  end

  assign bus.in_full   = full;
  assign bus.out_write = grant_valid;
  assign bus.out_din   = grant_valid ? {grant_idx, heads[grant_idx]} : '0;
  assign bus.drop_err  = drop_q;
endmodule

`default_nettype wire
